conbus_arb: RTL and testbench
=============================

CONBUS_ARB -- requirements
Module: conbus_arb

Interface
REQ-001 Parameter N_MASTERS, default 2, number of bus masters (legal 1..4).
REQ-002 Parameter N_SLAVES, default 4, number of address windows (power of two, 2..8).
REQ-003 Parameter RD_LAT, default 1, slave read latency in cycles (legal 1..3).
REQ-004 Parameter SLAVE_EN, default all ones (N_SLAVES bits), per-slave present mask.
REQ-005 sys_clk  in  1  single clock for all logic.
REQ-006 sys_rst  in  1  synchronous, active-high reset.
REQ-007 m_req  in  N_MASTERS  per-master access request, held until m_ack.
REQ-008 m_we  in  N_MASTERS  per-master write enable (1 = write, 0 = read).
REQ-009 m_a  in  16*N_MASTERS  per-master word address, master i at bits [16i+15:16i].
REQ-010 m_wdat  in  16*N_MASTERS  per-master write data.
REQ-011 m_rdat  out  16  read data, shared, valid when any m_ack bit is set.
REQ-012 m_ack  out  N_MASTERS  one-cycle completion pulse to the granted master.
REQ-013 s_a  out  16  shared slave address.
REQ-014 s_wdat  out  16  shared slave write data.
REQ-015 s_we  out  N_SLAVES  per-slave write strobe.
REQ-016 s_rdat  in  16*N_SLAVES  per-slave read data.
REQ-017 bus_err  out  1  one-cycle pulse when an access targets a slave with SLAVE_EN bit 0.

Function
REQ-018 Slave select SHALL be m_a[15:16-log2(N_SLAVES)]; s_a SHALL carry the full 16-bit latched address.
REQ-019 FSM states: IDLE, ACCESS, WAIT, DONE.
REQ-020 IDLE: if any m_req is set, arbitrate, latch grant index, address, we, and write data, then go to ACCESS; otherwise stay in IDLE.
REQ-021 Arbitration SHALL be round-robin: search starts at the master after the last granted one, wrapping modulo N_MASTERS.
REQ-022 ACCESS, one cycle: drive s_a and s_wdat from the latches, and set s_we[sel] = latched we AND SLAVE_EN[sel].
  - Write: go to DONE.
  - Read: go to WAIT.
REQ-023 WAIT SHALL last RD_LAT cycles under a down-counter. On its last cycle, register s_rdat[sel] into m_rdat, or 16'h0000 if the slave is disabled. Then go to DONE.
REQ-024 DONE, one cycle: assert m_ack[grant]. If the slave is disabled, also pulse bus_err. Then go to IDLE.
REQ-025 Latency from request sampled in IDLE to m_ack: writes 2 cycles, reads 2+RD_LAT cycles.
REQ-026 s_we SHALL be all zero outside ACCESS; s_a and s_wdat SHALL hold their last values.
REQ-027 m_rdat SHALL hold its value until the next read completes. After a write, m_rdat content is unspecified to masters.
REQ-028 If m_req is dropped after grant, the transaction SHALL still complete and the ack SHALL still be issued.
REQ-029 Requests arriving in any state other than IDLE SHALL wait. There is no pre-emption.
REQ-030 A disabled-slave write SHALL produce no s_we pulse and SHALL still be acked.

Reset
REQ-031 On sys_rst, the block SHALL do all of the following in the same cycle:
  - FSM to IDLE, with any in-flight transaction abandoned and no ack issued;
  - m_ack = 0, bus_err = 0, s_we = 0;
  - m_rdat = 16'h0000, s_a = 16'h0000, s_wdat = 16'h0000;
  - wait counter = 0;
  - round-robin pointer set so that master 0 has highest priority.

Structure
REQ-032 Package conbus_pkg SHALL hold the FSM state encoding, the data/address width constants (16), and a clog2 helper function.
REQ-033 Arbitration SHALL live in sub-module rr_arbiter, parametrised by N_MASTERS. Its outputs are a one-hot grant and a pointer update on accept.

Verification
REQ-034 N_MASTERS=2, RD_LAT=1: m0 writes 16'hBEEF to 16'h4002 -> s_we[1] pulses for one cycle with s_a=16'h4002 and s_wdat=16'hBEEF; m_ack[0] arrives 2 cycles after the request.
REQ-035 m0 reads 16'h4002 while slave 1 returns 16'hBEEF -> m_rdat=16'hBEEF with m_ack[0] 3 cycles after the request. Repeat with RD_LAT=3 -> 5 cycles.
REQ-036 m0 and m1 request continuously from reset -> grants alternate m0, m1, m0, m1, and no master is acked twice in a row.
REQ-037 SLAVE_EN=4'b0111, read 16'hC000 -> m_rdat=16'h0000 with bus_err and m_ack in the same cycle. Write 16'hC000 -> no s_we activity, ack and bus_err still pulse.
REQ-038 sys_rst asserted during WAIT -> no m_ack follows. The next request from m1 alone is served normally, and on a tie after reset m0 wins first.

Source files
------------

// File: rtl/conbus_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | conbus_pkg                                                           |
// | Shared widths, FSM encoding and clog2 helper for the conbus arbiter. |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
package conbus_pkg;

  localparam int DW = 16;
  localparam int AW = 16;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ACCESS = 2'd1,
    ST_WAIT   = 2'd2,
    ST_DONE   = 2'd3
  } state_t;

  function automatic int clog2(input int v);
    int r;
    r = 0;
    for (int i = 0; i < 31; i++) begin
      if ((1 << i) < v) r = i + 1;
    end
    return r;
  endfunction

endpackage
`default_nettype wire

// File: rtl/conbus_arb_rr_arbiter.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | rr_arbiter                                                           |
// | Round-robin request arbiter; pointer tracks the last accepted grant. |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
module rr_arbiter
  import conbus_pkg::*;
#(
  parameter int N_MASTERS = 2
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [N_MASTERS-1:0] i_req,
  input  logic                 i_accept,
  output logic [N_MASTERS-1:0] o_gnt
);

  localparam int IW = (N_MASTERS > 1) ? clog2(N_MASTERS) : 1;
  // Pointer resets to the last master so the search begins at master 0.
  localparam logic [IW-1:0] PTR_RST = IW'(N_MASTERS - 1);

  logic [IW-1:0]        r_ptr;
  logic [IW-1:0]        w_idx;
  logic [N_MASTERS-1:0] w_gnt;
  logic                 w_found;
  int                   w_j;

  always_comb begin
    w_gnt   = '0;
    w_idx   = '0;
    w_found = 1'b0;
    w_j     = 0;
    for (int k = 1; k <= N_MASTERS; k++) begin
      w_j = (int'(r_ptr) + k) % N_MASTERS;
      if (!w_found && i_req[w_j[IW-1:0]]) begin
        w_found             = 1'b1;
        w_idx               = w_j[IW-1:0];
        w_gnt[w_j[IW-1:0]]  = 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_ptr <= PTR_RST;
    end else if (i_accept && w_found) begin
      r_ptr <= w_idx;
    end
  end

  assign o_gnt = w_gnt;

endmodule
`default_nettype wire

// File: rtl/conbus_arb.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | conbus_arb                                                           |
// | Multi-master to windowed multi-slave bus arbiter with read latency.  |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
module conbus_arb
  import conbus_pkg::*;
#(
  parameter int                  N_MASTERS = 2,
  parameter int                  N_SLAVES  = 4,
  parameter int                  RD_LAT    = 1,
  parameter logic [N_SLAVES-1:0] SLAVE_EN  = '1
) (
  input  logic                    sys_clk,
  input  logic                    sys_rst,
  input  logic [N_MASTERS-1:0]    m_req,
  input  logic [N_MASTERS-1:0]    m_we,
  input  logic [AW*N_MASTERS-1:0] m_a,
  input  logic [DW*N_MASTERS-1:0] m_wdat,
  output logic [DW-1:0]           m_rdat,
  output logic [N_MASTERS-1:0]    m_ack,
  output logic [AW-1:0]           s_a,
  output logic [DW-1:0]           s_wdat,
  output logic [N_SLAVES-1:0]     s_we,
  input  logic [DW*N_SLAVES-1:0]  s_rdat,
  output logic                    bus_err
);

  localparam int         SEL_W  = clog2(N_SLAVES);
  localparam logic [1:0] LAT_M1 = 2'(RD_LAT - 1);

  state_t               r_state, w_next;
  logic [N_MASTERS-1:0] w_gnt, r_gnt;
  logic [AW-1:0]        r_addr, w_ma;
  logic [DW-1:0]        r_wdat, w_mwd;
  logic                 r_we, w_mwe;
  logic [1:0]           r_cnt;
  logic                 w_accept;
  logic [SEL_W-1:0]     w_sel;
  logic                 w_en;
  logic [DW-1:0]        w_srd;

  assign w_accept = (r_state == ST_IDLE) && (|m_req);
  assign w_sel    = r_addr[AW-1 -: SEL_W];
  assign w_en     = SLAVE_EN[w_sel];
  assign w_srd    = s_rdat[w_sel*DW +: DW];

  rr_arbiter #(
    .N_MASTERS (N_MASTERS)
  ) u_rr_arbiter (
    .clk      (sys_clk),
    .rst      (sys_rst),
    .i_req    (m_req),
    .i_accept (w_accept),
    .o_gnt    (w_gnt)
  );

  always_comb begin
    w_ma  = '0;
    w_mwd = '0;
    w_mwe = 1'b0;
    for (int i = 0; i < N_MASTERS; i++) begin
      if (w_gnt[i]) begin
        w_ma  = m_a[i*AW +: AW];
        w_mwd = m_wdat[i*DW +: DW];
        w_mwe = m_we[i];
      end
    end
  end

  always_ff @(posedge sys_clk) begin
    if (sys_rst) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      ST_IDLE:   if (w_accept) w_next = ST_ACCESS;
      ST_ACCESS: w_next = r_we ? ST_DONE : ST_WAIT;
      ST_WAIT:   if (r_cnt == 2'd0) w_next = ST_DONE;
      ST_DONE:   w_next = ST_IDLE;
      default:   w_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge sys_clk) begin
    if (sys_rst) begin
      r_gnt  <= '0;
      r_addr <= '0;
      r_wdat <= '0;
      r_we   <= 1'b0;
      r_cnt  <= 2'd0;
      m_rdat <= '0;
    end else begin
      if (w_accept) begin
        r_gnt  <= w_gnt;
        r_addr <= w_ma;
        r_wdat <= w_mwd;
        r_we   <= w_mwe;
      end
      if (r_state == ST_ACCESS && !r_we) begin
        r_cnt <= LAT_M1;
      end else if (r_state == ST_WAIT && r_cnt != 2'd0) begin
        r_cnt <= r_cnt - 2'd1;
      end
      // Absent slaves read as zero rather than floating bus data.
      if (r_state == ST_WAIT && r_cnt == 2'd0) begin
        m_rdat <= w_en ? w_srd : '0;
      end
    end
  end

  always_comb begin
    s_we = '0;
    if (r_state == ST_ACCESS) s_we[w_sel] = r_we & w_en;
  end

  assign m_ack   = (r_state == ST_DONE) ? r_gnt : '0;
  assign bus_err = (r_state == ST_DONE) && !w_en;
  assign s_a     = r_addr;
  assign s_wdat  = r_wdat;

endmodule
`default_nettype wire

// File: tb/tb_conbus_arb.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | tb_conbus_arb                                                        |
// | Scoreboard bench for conbus_arb (RD_LAT=1 w/ absent slave, RD_LAT=3).|
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
module tb_conbus_arb;

  logic sys_clk = 1'b0;
  logic sys_rst = 1'b1;
  always #5 sys_clk = ~sys_clk;

  logic [1:0]  a_req = '0, a_we = '0;
  logic [31:0] a_a = '0, a_wd = '0;
  logic [15:0] a_rdat, a_sa, a_swd;
  logic [1:0]  a_ack;
  logic [3:0]  a_swe;
  logic        a_err;

  logic [1:0]  b_req = '0, b_we = '0;
  logic [31:0] b_a = '0, b_wd = '0;
  logic [15:0] b_rdat, b_sa, b_swd;
  logic [1:0]  b_ack;
  logic [3:0]  b_swe;
  logic        b_err;

  logic [63:0] srd = {16'h3333, 16'h2222, 16'hBEEF, 16'h1111};

  conbus_arb #(.N_MASTERS(2), .N_SLAVES(4), .RD_LAT(1), .SLAVE_EN(4'b0111)) u_dut_a (
    .sys_clk(sys_clk), .sys_rst(sys_rst), .m_req(a_req), .m_we(a_we), .m_a(a_a),
    .m_wdat(a_wd), .m_rdat(a_rdat), .m_ack(a_ack), .s_a(a_sa), .s_wdat(a_swd),
    .s_we(a_swe), .s_rdat(srd), .bus_err(a_err));

  conbus_arb #(.N_MASTERS(2), .N_SLAVES(4), .RD_LAT(3), .SLAVE_EN(4'b1111)) u_dut_b (
    .sys_clk(sys_clk), .sys_rst(sys_rst), .m_req(b_req), .m_we(b_we), .m_a(b_a),
    .m_wdat(b_wd), .m_rdat(b_rdat), .m_ack(b_ack), .s_a(b_sa), .s_wdat(b_swd),
    .s_we(b_swe), .s_rdat(srd), .bus_err(b_err));

  typedef struct {
    int          m;
    bit          rd;
    logic [15:0] rdat;
    bit          err;
    int          lat;
    int          t0;
  } exp_t;

  exp_t        sb[$];
  exp_t        mon_e;
  int          n_chk = 0, n_fail = 0;
  int          cyc = 0, n_acks = 0, last_m = 0, we_pulses = 0;
  logic [3:0]  last_swe = '0;
  logic [15:0] last_sa = '0, last_swd = '0;

  always @(posedge sys_clk) cyc <= cyc + 1;

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", tag, act, exp);
    end
  endtask

  always @(negedge sys_clk) begin
    if (a_ack != 2'b00) begin
      if (sb.size() == 0) begin
        chk("spurious_ack", 32'(a_ack), 32'd0);
      end else begin
        mon_e = sb.pop_front();
        chk("ack_grant", 32'(a_ack), 32'(1 << mon_e.m));
        if (mon_e.rd) chk("rdat", 32'(a_rdat), 32'(mon_e.rdat));
        chk("bus_err", 32'(a_err), 32'(mon_e.err));
        if (mon_e.lat >= 0) chk("latency", cyc - mon_e.t0, mon_e.lat);
      end
      last_m = a_ack[1] ? 1 : 0;
      n_acks++;
    end else if (a_err) begin
      chk("err_without_ack", 32'(a_err), 32'd0);
    end
    if (a_swe != 4'b0000) begin
      we_pulses++;
      last_swe = a_swe;
      last_sa  = a_sa;
      last_swd = a_swd;
    end
  end

  task automatic wait_acks(input int tgt, input int budget, input bit drop_each);
    int seen;
    seen = n_acks;
    for (int i = 0; i < budget && n_acks < tgt; i++) begin
      @(posedge sys_clk);
      if (drop_each && n_acks != seen) begin
        #1 a_req[last_m] = 1'b0;
        seen = n_acks;
      end
    end
    if (n_acks < tgt) chk("ack_timeout", n_acks, tgt);
    #1;
  endtask

  task automatic do_txn(input int m, input bit we, input logic [15:0] addr, input logic [15:0] wd,
                        input logic [15:0] rexp, input bit err, input int lat);
    @(posedge sys_clk);
    #1;
    a_we[m]          = we;
    a_a[m*16 +: 16]  = addr;
    a_wd[m*16 +: 16] = wd;
    a_req[m]         = 1'b1;
    sb.push_back('{m, !we, rexp, err, lat, cyc});
    wait_acks(n_acks + 1, 20, 1'b0);
    a_req = '0;
  endtask

  task automatic chk_reset(input string tag);
    chk({tag, "_ack"},  32'(a_ack),  32'd0);
    chk({tag, "_err"},  32'(a_err),  32'd0);
    chk({tag, "_swe"},  32'(a_swe),  32'd0);
    chk({tag, "_rdat"}, 32'(a_rdat), 32'd0);
    chk({tag, "_sa"},   32'(a_sa),   32'd0);
    chk({tag, "_swd"},  32'(a_swd),  32'd0);
  endtask

  initial begin
    int w0, n0, t0;
    repeat (3) @(posedge sys_clk);
    @(negedge sys_clk);
    chk_reset("reset");

    // Both masters request straight out of reset: strict alternation.
    @(posedge sys_clk);
    #1;
    a_we = 2'b11; a_a = {16'h2020, 16'h0010}; a_wd = {16'h0B0B, 16'h0A0A};
    a_req = 2'b11; sys_rst = 1'b0;
    for (int i = 0; i < 4; i++) sb.push_back('{i % 2, 1'b0, 16'h0, 1'b0, -1, cyc});
    wait_acks(n_acks + 4, 40, 1'b0);
    a_req = '0;

    w0 = we_pulses;
    do_txn(0, 1'b1, 16'h4002, 16'hBEEF, 16'h0, 1'b0, 2);
    chk("wr_pulses", we_pulses - w0, 1);
    chk("wr_swe", 32'(last_swe), 32'h2);
    chk("wr_sa", 32'(last_sa), 32'h4002);
    chk("wr_swd", 32'(last_swd), 32'hBEEF);

    do_txn(0, 1'b0, 16'h4002, 16'h0, 16'hBEEF, 1'b0, 3);
    do_txn(0, 1'b0, 16'hC000, 16'h0, 16'h0000, 1'b1, 3);
    w0 = we_pulses;
    do_txn(1, 1'b1, 16'hC000, 16'h5555, 16'h0, 1'b1, 2);
    chk("dis_wr_pulses", we_pulses - w0, 0);

    @(posedge sys_clk);
    #1;
    b_we = '0; b_a[15:0] = 16'h4002; b_req = 2'b01; t0 = cyc;
    for (int i = 0; i < 20; i++) begin
      @(negedge sys_clk);
      if (b_ack != 2'b00) break;
    end
    chk("b_latency", cyc - t0, 5);
    chk("b_ack", 32'(b_ack), 32'h1);
    chk("b_rdat", 32'(b_rdat), 32'hBEEF);
    @(posedge sys_clk);
    #1 b_req = '0;

    do_txn(1, 1'b0, 16'h4002, 16'h0, 16'hBEEF, 1'b0, 3);

    // Reset lands while the read sits in WAIT; nothing may be acked.
    n0 = n_acks;
    @(posedge sys_clk);
    #1;
    a_we = '0; a_a[15:0] = 16'h1000; a_req = 2'b01;
    @(posedge sys_clk);
    @(posedge sys_clk);
    #1;
    sys_rst = 1'b1; a_req = '0;
    @(posedge sys_clk);
    #1 sys_rst = 1'b0;
    repeat (8) @(posedge sys_clk);
    @(negedge sys_clk);
    chk("abort_acks", n_acks - n0, 0);
    chk_reset("abort");

    do_txn(1, 1'b0, 16'h4002, 16'h0, 16'hBEEF, 1'b0, 3);
    do_txn(0, 1'b1, 16'h0004, 16'h1234, 16'h0, 1'b0, 2);

    @(posedge sys_clk);
    #1 sys_rst = 1'b1;
    @(posedge sys_clk);
    #1;
    sys_rst = 1'b0;
    a_we = 2'b11; a_a = {16'h0008, 16'h000C}; a_req = 2'b11;
    sb.push_back('{0, 1'b0, 16'h0, 1'b0, -1, cyc});
    sb.push_back('{1, 1'b0, 16'h0, 1'b0, -1, cyc});
    wait_acks(n_acks + 2, 30, 1'b1);
    a_req = '0;

    repeat (3) @(posedge sys_clk);
    chk("sb_empty", sb.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
